// File: rtl/cnn_pkg.sv
// Shared definitions for the accelerator output path.
//   packer_state_t : ofmap_packer control states (IDLE/RUN/FLUSH/DONE)
//   DATA_WIDTH_DEF / SRAM_DATA_WIDTH_DEF : default element and packed-word widths
//   sat_int8()     : clamp a signed 16-bit value into the int8 range
package cnn_pkg;

  localparam int DATA_WIDTH_DEF      = 8;
  localparam int SRAM_DATA_WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } packer_state_t;

  localparam logic signed [15:0] SAT_MAX = 16'sd127;
  localparam logic signed [15:0] SAT_MIN = -16'sd128;

  function automatic logic [7:0] sat_int8(input logic signed [15:0] v);
    logic [7:0] res;
    if (v > SAT_MAX) begin
      res = 8'h7F;
    end else if (v < SAT_MIN) begin
      res = 8'h80;
    end else begin
      res = v[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO holding packed output words.
//   clk_i, rst_i (async, active-high), clr_i (synchronous clear)
//   push_i/data_i   : write side; a push while full is dropped unless a pop
//                     happens in the same cycle
//   pop_i           : consume the head (only effective while valid_o is high)
//   valid_o/data_o  : head of queue; data_o reads 0 while valid_o is low
//   full_o, empty_o, count_o : occupancy
// The read-side valid is registered: a word pushed into an empty FIFO becomes
// visible one cycle after the push, while pops take effect immediately.
// DEPTH must be a power of two, at least 2.
module word_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             valid_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_pop  = pop_i && valid_q;
  assign do_push = push_i && (!full_o || do_pop);

  assign valid_o = valid_q;
  assign data_o  = valid_q ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
      // Entries pushed this cycle are deliberately excluded here, which is
      // what delays their appearance at the read side by one cycle.
      valid_q <= ((count_q - CW'(do_pop)) != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ofmap_packer.sv
// Output-feature-map packer: requantizes the 16-bit accumulator stream
// (optional ReLU, arithmetic right shift, int8 saturation), packs eight
// results per 64-bit word and writes the words to the output SRAM.
//   i_clk, i_rst (async, active-high)
//   i_start, i_relu_en, i_shift, i_base_addr : layer configuration (IDLE only)
//   i_ofmap, i_ofmap_valid, i_done           : upstream result stream
//   o_wr_en, o_wr_addr, o_wr_data, i_wr_ready: SRAM write port
//   o_busy, o_done, o_overflow, o_word_count : status
//   o_state                                   : current control state (debug)
// Write handshake: o_wr_en is the valid; a word transfers on a rising edge
// where o_wr_en && i_wr_ready. While o_wr_en is high and not accepted, the
// address and data are held stable.
module ofmap_packer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int SRAM_DATA_WIDTH = SRAM_DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_relu_en,
  input  logic [3:0]                 i_shift,
  input  logic [ADDR_WIDTH-1:0]      i_base_addr,
  input  logic [2*DATA_WIDTH-1:0]    i_ofmap,
  input  logic                       i_ofmap_valid,
  input  logic                       i_done,
  output logic                       o_wr_en,
  output logic [ADDR_WIDTH-1:0]      o_wr_addr,
  output logic [SRAM_DATA_WIDTH-1:0] o_wr_data,
  input  logic                       i_wr_ready,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_overflow,
  output logic [ADDR_WIDTH:0]        o_word_count,
  output logic [1:0]                 o_state
);

  localparam int IW        = 2 * DATA_WIDTH;
  localparam int LANES     = SRAM_DATA_WIDTH / DATA_WIDTH;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int FCW       = $clog2(FIFO_DEPTH) + 1;

  packer_state_t state_q, state_d;

  logic                       relu_q;
  logic [3:0]                 shift_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [ADDR_WIDTH:0]        wcnt_q;
  logic                       ovf_q;
  logic                       stg_valid_q;
  logic [DATA_WIDTH-1:0]      stg_data_q;
  logic [LANE_BITS-1:0]       lane_q;
  logic [SRAM_DATA_WIDTH-1:0] word_q;

  logic                       start_go;
  logic                       accept;
  logic signed [IW-1:0]       x_s, r_s, s_s;
  logic [DATA_WIDTH-1:0]      q_byte;
  logic [SRAM_DATA_WIDTH-1:0] word_merged;
  logic                       last_lane;
  logic                       push_full;
  logic                       push_part;
  logic                       push_req;
  logic [SRAM_DATA_WIDTH-1:0] push_data;
  logic                       pop;
  logic                       ovf_set;
  logic                       flush_done;

  logic                       fifo_valid;
  logic [SRAM_DATA_WIDTH-1:0] fifo_data;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [FCW-1:0]             fifo_count;

  assign start_go = (state_q == ST_IDLE) && i_start;
  // Elements are only taken in RUN; the element arriving with i_done is
  // still sampled in RUN, so it is processed without a special case.
  assign accept   = (state_q == ST_RUN) && i_ofmap_valid;

  // Requantization on the incoming element, registered into the stage.
  always_comb begin
    x_s    = signed'(i_ofmap);
    r_s    = (relu_q && x_s[IW-1]) ? '0 : x_s;
    s_s    = r_s >>> shift_q;
    q_byte = sat_int8(s_s);
  end

  always_comb begin
    word_merged = word_q;
    word_merged[lane_q*DATA_WIDTH +: DATA_WIDTH] = stg_data_q;
  end

  assign last_lane = (lane_q == LANE_BITS'(LANES - 1));
  assign push_full = stg_valid_q && last_lane;
  // Partial word goes out once the stage has drained during FLUSH; unused
  // lanes are already zero because word_q is cleared after every push.
  assign push_part = (state_q == ST_FLUSH) && !stg_valid_q && (lane_q != '0);
  assign push_req  = push_full || push_part;
  assign push_data = push_full ? word_merged : word_q;
  assign pop       = fifo_valid && i_wr_ready;
  assign ovf_set   = push_req && fifo_full && !pop;

  // Counting a pop in progress lets DONE follow the last transfer directly.
  assign flush_done = !stg_valid_q && (lane_q == '0) &&
                      (fifo_empty || ((fifo_count == FCW'(1)) && pop));

  word_fifo #(
    .WIDTH (SRAM_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .clr_i   (start_go),
    .push_i  (push_req),
    .data_i  (push_data),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start)    state_d = ST_RUN;
      ST_RUN:   if (i_done)     state_d = ST_FLUSH;
      ST_FLUSH: if (flush_done) state_d = ST_DONE;
      ST_DONE:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      relu_q      <= 1'b0;
      shift_q     <= '0;
      addr_q      <= '0;
      wcnt_q      <= '0;
      ovf_q       <= 1'b0;
      stg_valid_q <= 1'b0;
      stg_data_q  <= '0;
      lane_q      <= '0;
      word_q      <= '0;
    end else if (start_go) begin
      relu_q      <= i_relu_en;
      shift_q     <= i_shift;
      addr_q      <= i_base_addr;
      wcnt_q      <= '0;
      ovf_q       <= 1'b0;
      stg_valid_q <= 1'b0;
      lane_q      <= '0;
      word_q      <= '0;
    end else begin
      stg_valid_q <= accept;
      if (accept) stg_data_q <= q_byte;
      if (stg_valid_q) begin
        if (last_lane) begin
          lane_q <= '0;
          word_q <= '0;
        end else begin
          lane_q <= lane_q + LANE_BITS'(1);
          word_q <= word_merged;
        end
      end else if (push_part) begin
        lane_q <= '0;
        word_q <= '0;
      end
      if (pop) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        wcnt_q <= wcnt_q + (ADDR_WIDTH+1)'(1);
      end
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  assign o_wr_en      = fifo_valid;
  assign o_wr_data    = fifo_data;
  assign o_wr_addr    = addr_q;
  assign o_busy       = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign o_done       = (state_q == ST_DONE);
  assign o_overflow   = ovf_q;
  assign o_word_count = wcnt_q;
  assign o_state      = state_q;

endmodule

// File: doc/ofmap_packer.md
# ofmap_packer

Downstream stage of the accelerator `top`. It consumes the 16-bit signed `o_ofmap`/`o_ofmap_valid` stream and the `o_done` pulse, and applies optional ReLU, an arithmetic right-shift requantization and int8 saturation. It packs eight results per 64-bit word and writes them to the output SRAM through a valid/ready write port, buffered by a small FIFO. Any partial word is flushed on layer completion.

## Interface
- `DATA_WIDTH`, 8, output element width; input element is 2*DATA_WIDTH.
- `SRAM_DATA_WIDTH`, 64, packed word width; LANES = SRAM_DATA_WIDTH/DATA_WIDTH = 8.
- `ADDR_WIDTH`, 8, output SRAM address width.
- `FIFO_DEPTH`, 4, packed-word buffer depth (power of two).
- `i_clk` input 1: sole clock, rising edge.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_start` input 1: begin a layer; honoured only in IDLE.
- `i_relu_en` input 1: clamp negatives to 0 before shifting; sampled on `i_start`.
- `i_shift` input 4: arithmetic right-shift amount 0..15; sampled on `i_start`.
- `i_base_addr` input ADDR_WIDTH: first write address; sampled on `i_start`.
- `i_ofmap` input 2*DATA_WIDTH: signed accumulator result.
- `i_ofmap_valid` input 1: `i_ofmap` is valid this cycle; there is no backpressure.
- `i_done` input 1: the upstream layer is finished, one-cycle pulse.
- `o_wr_en` output 1: write request (valid).
- `o_wr_addr` output ADDR_WIDTH: write address.
- `o_wr_data` output SRAM_DATA_WIDTH: packed word; element k sits in bits [8k+7:8k].
- `i_wr_ready` input 1: the SRAM accepts the write.
- `o_busy` output 1: high in RUN and FLUSH.
- `o_done` output 1: one-cycle pulse when all words are written.
- `o_overflow` output 1: sticky; a word was dropped because the FIFO was full.
- `o_word_count` output ADDR_WIDTH+1: number of words accepted by the SRAM this layer.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE → RUN on `i_start`. This loads the configuration, sets address = `i_base_addr`, and clears the lane counter, word count, FIFO and `o_overflow`.
  - RUN → FLUSH on `i_done`.
  - FLUSH → DONE when the requant stage is empty, no partial word is pending, and the FIFO is empty.
  - DONE → IDLE unconditionally after one cycle; `o_done` is high during DONE.
- `i_start` outside IDLE is ignored.
- `i_ofmap_valid` is ignored in IDLE and DONE. In FLUSH it is also ignored, except for the element that arrives in the same cycle as `i_done`, which is processed.
- Requantization: r = (relu_en && x<0) ? 0 : x; s = r >>> shift (sign-extending, rounds toward −inf); y = saturate(s, −128, 127).
- Packing: lanes fill 0→7. Completing lane 7 pushes the word into the FIFO and resets the lane counter.
- Flush: if the lane counter is >0 after the last element, the partial word is pushed with unused lanes zero-filled.
- Write port: the FIFO head drives `o_wr_en`/`o_wr_data`. A transfer happens when `o_wr_en && i_wr_ready`. On each transfer the address increments and wraps modulo 2^ADDR_WIDTH, and `o_word_count` increments.
- Overflow: if a push occurs while the FIFO is full and no pop happens that cycle, the word is dropped and `o_overflow` is set. A push and pop in the same cycle when full is legal.
- All outputs reset to 0. `o_wr_addr` resets to 0. State resets to IDLE.

## Timing
- Requant stage is a single registered stage. An element sampled at edge E is held in the stage register after E.
- Lane write happens at edge E+1. The FIFO push for lane 7 also happens at edge E+1.
- `o_wr_en` rises after edge E+2 when the FIFO was empty (registered FIFO read side).
- The FIFO sustains one push and one pop per cycle. With `i_wr_ready` tied high and continuous valid input, throughput is one word every 8 cycles and the FIFO never exceeds 1 entry.
- `i_done` at edge D with a partial word pending: the partial push happens at D+2 at the earliest; `o_done` is high the cycle after the last transfer.
- `o_wr_en` stays asserted with stable data and address until accepted.
- `i_rst` at any time, including mid-burst, returns the block to IDLE immediately. Pending words are discarded and all outputs go to 0.

## Structure
- Shared package `cnn_pkg`:
  - `packer_state_t` enum (IDLE/RUN/FLUSH/DONE);
  - DATA_WIDTH/SRAM_DATA_WIDTH defaults;
  - `sat_int8` saturation function.
- Sub-module `word_fifo`: parameterized synchronous FIFO with full, empty and count outputs, async active-high reset. Everything else stays in `ofmap_packer`.

## Test plan
- Full-word packing: base 0x10, no ReLU, shift 0, stream 1..8 → one write, addr 0x10, data 0x0807060504030201; `o_done` pulses after the transfer; `o_word_count`=1.
- Requant/ReLU: shift 4, ReLU on; inputs 0x0800, 0xFFF0, 0x7FFF, 0x0010 plus four zeros → bytes 0x7F, 0x00, 0x7F, 0x01, 0, 0, 0, 0. With ReLU off, 0xFFF0 → 0xFF.
- Partial flush: 11 elements (0x01..0x0B), then `i_done` in the same cycle as the 11th → two writes; the second word is 0x00000000000B0A09 at base+1.
- Backpressure/overflow: hold `i_wr_ready` low while 48 elements stream in → 4 words buffered, 2 dropped, `o_overflow`=1. Releasing ready writes exactly 4 words at consecutive addresses.
- Address wrap: base 0xFF, 16 elements → writes at 0xFF then 0x00.
- Reset mid-operation: assert `i_rst` while `o_wr_en`=1 → all outputs 0 asynchronously, state IDLE. The next `i_start` run behaves as the first test.
